mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between instruction fetch (read-only) and the load/store path (read/write).
- Sits between the IF stage / load-store unit and the `Instruction_and_data` memory in `SCC`.
- Issues at most one memory transaction at a time and returns read data with a valid pulse.
- Drives a `stall` toward IF while a fetch is pending but not granted.
- Data requests have priority over fetch; a starvation limit guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- MEM_LAT, 1, cycles from `mem_en` issue to `mem_rdata` valid; legal range 1..4.
- MAX_WAIT, 3, consecutive lost-arbitration cycles after which fetch wins. 0 means fetch always has priority.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; `if_rdata` valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_gnt`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse, for both load and store.
- d_rdata  out  DATA_W  load data; 0 on store completion.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue.
- stall  out  1  `if_req & ~if_gnt`; forced 0 during reset.

Behaviour:
- States:
  - IDLE: no transaction outstanding.
  - BUSY: transaction outstanding. Registers: `owner` (IF/DATA), `lat_cnt`.
- Issue cycle: allowed in IDLE, or in BUSY on the cycle `lat_cnt` reaches MEM_LAT (the response cycle).
  - Back-to-back transactions are allowed; with MEM_LAT=1 throughput is one access per cycle.
- Arbitration, evaluated in the issue cycle:
  - Winner = DATA if `d_req` and not (`if_req` and `wait_cnt`==MAX_WAIT).
  - Otherwise winner = IF if `if_req`.
  - Otherwise no issue.
- On issue (combinational in the same cycle):
  - `mem_en`=1 and `gnt` of the winner = 1.
  - `mem_addr`/`mem_we`/`mem_wdata` taken from the winner; IF forces `mem_we`=0 and `mem_wdata`=0.
  - Next cycle: BUSY, `owner` = winner, `lat_cnt`=1.
- BUSY: `lat_cnt` increments each cycle. When `lat_cnt`==MAX... correction: when `lat_cnt`==MEM_LAT:
  - Owner's `rvalid` = 1.
  - Owner's `rdata` = `mem_rdata` (`d_rdata`=0 for stores).
  - Return to IDLE unless a new issue occurs in the same cycle.
- `rdata` outputs are 0 whenever the matching `rvalid`=0.
- Non-issue cycles: `mem_en`=0, `mem_we`=0; `mem_addr`/`mem_wdata` = 0.
- wait_cnt:
  - +1 on each cycle with `if_req`=1 and `if_gnt`=0, saturating at MAX_WAIT.
  - Cleared on `if_gnt` or when `if_req`=0.
- Simultaneous `if_req`/`d_req`: DATA wins; IF loses, `stall`=1, `wait_cnt` increments.
- Request deassertion before grant is legal; nothing is issued for that requester.
- Reset (async, any time): state→IDLE, `owner`, `lat_cnt`, `wait_cnt` → 0.
  - Outstanding transaction is dropped; no `rvalid` is emitted for it.
  - All outputs are 0 while `reset`=0.
- Both gnt signals are never 1 in the same cycle; both rvalid signals are never 1 in the same cycle.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs `if_stall_cnt` [31:0] (cycles with `stall`=1) and `d_conflict_cnt` [31:0] (issue cycles where both requested).
  - Both are wrapping counters, cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package `scc_mem_pkg`:
  - `owner_t` {OWN_NONE, OWN_IF, OWN_DATA}.
  - `arb_state_t` {ARB_IDLE, ARB_BUSY}.
  - Default ADDR_W/DATA_W constants.
- Sub-module `mem_arb_age_ctr`: saturating starvation counter. Inputs: `req`, `gnt`, MAX_WAIT. Output: `expired`.

Test Plan:
- Single fetch, MEM_LAT=1: `if_req`, `if_addr`=0x10 at cycle 0 → `if_gnt`, `mem_en`, `mem_addr`=0x10 at cycle 0; `if_rvalid`=1, `if_rdata`=`mem_rdata` at cycle 1.
- Store then load to 0x40, MEM_LAT=2: store `d_wdata`=0xDEADBEEF; `d_rvalid` with `d_rdata`=0 two cycles later. Load issued on that cycle returns 0xDEADBEEF two cycles after its issue.
- Contention, MAX_WAIT=3: `d_req` and `if_req` held high → DATA wins 3 consecutive grants, `stall`=1. IF is granted on the 4th, `wait_cnt` cleared, then DATA resumes.
- Back-to-back fetches, MEM_LAT=1: `if_req` held with addresses 0,4,8 → `if_gnt` every cycle, `if_rvalid` every cycle from cycle 1, `stall`=0.
- Reset mid-operation: `reset`=0 one cycle after a data load issue, MEM_LAT=3 → no `d_rvalid`, all outputs 0. After release, a new fetch completes normally.
- ARB_PERF_CNT_EN: contention scenario for 8 cycles → `d_conflict_cnt` and `if_stall_cnt` match bench-counted values.

Source files
------------

// File: rtl/scc_mem_pkg.sv
// Shared types and default widths for the SCC unified-memory port arbiter.
package scc_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Latency counter width; holds MEM_LAT values up to 7.
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arb_age_ctr.sv
// Saturating starvation counter for the fetch requester. Counts cycles in
// which fetch is requesting but not granted. It asserts o_expired once the
// count reaches MAX_WAIT. MAX_WAIT = 0 keeps o_expired permanently high, so
// fetch always wins.
module mem_arb_age_ctr
  import scc_mem_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_expired
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;

  // Age the pending fetch; a grant or a withdrawn request starts over from zero.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port unified instruction/data memory. It places one
// transaction in flight at a time. Data requests win unless fetch has starved
// for MAX_WAIT cycles. The response cycle may also issue the next transaction,
// so with MEM_LAT = 1 the memory sustains one access per cycle.
// Optional build macro ARB_PERF_CNT_EN adds the stall and conflict counters.
module mem_port_arbiter
  import scc_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_stall
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       o_if_stall_cnt,
  output logic [31:0]       o_d_conflict_cnt
`endif
);

  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MEM_LAT);

  arb_state_t       r_state, w_state_nxt;
  owner_t           r_owner, w_owner_nxt;
  logic [LAT_W-1:0] r_lat_cnt, w_lat_nxt;
  logic             r_store, w_store_nxt;

  logic w_resp;
  logic w_issue_ok;
  logic w_d_win;
  logic w_if_win;
  logic w_expired;

  mem_arb_age_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_age (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req    (i_if_req),
    .i_gnt    (o_if_gnt),
    .o_expired(w_expired)
  );

  // Hold the outstanding transaction: state, owner, latency count, store flag.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWN_NONE;
      r_lat_cnt <= '0;
      r_store   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_store   <= w_store_nxt;
    end
  end

  // Retire the response, pick a winner, and drive the memory port. Reset gates every output low.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_lat_nxt   = r_lat_cnt;
    w_store_nxt = r_store;
    w_resp      = 1'b0;
    w_issue_ok  = 1'b0;
    w_d_win     = 1'b0;
    w_if_win    = 1'b0;
    o_if_gnt    = 1'b0;
    o_if_rvalid = 1'b0;
    o_if_rdata  = '0;
    o_d_gnt     = 1'b0;
    o_d_rvalid  = 1'b0;
    o_d_rdata   = '0;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_stall     = 1'b0;
    if (i_reset) begin
      w_resp     = (r_state == ARB_BUSY) && (r_lat_cnt == LAT_END);
      w_issue_ok = (r_state == ARB_IDLE) || w_resp;
      if (r_state == ARB_BUSY) begin
        w_lat_nxt = r_lat_cnt + LAT_W'(1);
      end
      if (w_resp) begin
        w_state_nxt = ARB_IDLE;
        w_owner_nxt = OWN_NONE;
        w_lat_nxt   = '0;
        w_store_nxt = 1'b0;
        if (r_owner == OWN_IF) begin
          o_if_rvalid = 1'b1;
          o_if_rdata  = i_mem_rdata;
        end else if (r_owner == OWN_DATA) begin
          o_d_rvalid = 1'b1;
          o_d_rdata  = r_store ? '0 : i_mem_rdata;
        end
      end
      if (w_issue_ok) begin
        if (i_d_req && !(i_if_req && w_expired)) begin
          w_d_win = 1'b1;
        end else if (i_if_req) begin
          w_if_win = 1'b1;
        end
      end
      if (w_d_win) begin
        o_d_gnt     = 1'b1;
        o_mem_en    = 1'b1;
        o_mem_we    = i_d_we;
        o_mem_addr  = i_d_addr;
        o_mem_wdata = i_d_wdata;
        w_state_nxt = ARB_BUSY;
        w_owner_nxt = OWN_DATA;
        w_lat_nxt   = LAT_W'(1);
        w_store_nxt = i_d_we;
      end else if (w_if_win) begin
        o_if_gnt    = 1'b1;
        o_mem_en    = 1'b1;
        o_mem_addr  = i_if_addr;
        w_state_nxt = ARB_BUSY;
        w_owner_nxt = OWN_IF;
        w_lat_nxt   = LAT_W'(1);
        w_store_nxt = 1'b0;
      end
      o_stall = i_if_req && !o_if_gnt;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_if_stall_cnt;
  logic [31:0] r_d_conflict_cnt;

  // Count stalled fetch cycles and issue cycles where both sides wanted the port.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_if_stall_cnt   <= '0;
      r_d_conflict_cnt <= '0;
    end else begin
      if (o_stall) begin
        r_if_stall_cnt <= r_if_stall_cnt + 32'd1;
      end
      if (w_issue_ok && i_if_req && i_d_req) begin
        r_d_conflict_cnt <= r_d_conflict_cnt + 32'd1;
      end
    end
  end

  assign o_if_stall_cnt   = r_if_stall_cnt;
  assign o_d_conflict_cnt = r_d_conflict_cnt;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances share one stimulus set:
// index k runs with MEM_LAT = k+1 and MAX_WAIT = 3. Each test checks only the
// instance whose latency matches its scenario. Every instance has a private
// memory model. A location that has never been written reads back as
// 0xA000_0000 | addr.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        ifReq = 1'b0;
  logic [31:0] ifAddr = '0;
  logic        dReq = 1'b0;
  logic        dWe = 1'b0;
  logic [31:0] dAddr = '0;
  logic [31:0] dWdata = '0;

  logic        ifGnt    [3];
  logic        ifRvalid [3];
  logic [31:0] ifRdata  [3];
  logic        dGnt     [3];
  logic        dRvalid  [3];
  logic [31:0] dRdata   [3];
  logic        memEn    [3];
  logic        memWe    [3];
  logic [31:0] memAddr  [3];
  logic [31:0] memWdata [3];
  logic [31:0] memRdata [3];
  logic        stall    [3];
`ifdef ARB_PERF_CNT_EN
  logic [31:0] ifStallCnt   [3];
  logic [31:0] dConflictCnt [3];
`endif

  logic [31:0] memArr     [3][256];
  logic        memWritten [3][256];
  logic [31:0] pipe       [3][4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    mem_port_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .MEM_LAT (g + 1),
      .MAX_WAIT(3)
    ) uDut (
      .i_clk      (clk),
      .i_reset    (rstN),
      .i_if_req   (ifReq),
      .i_if_addr  (ifAddr),
      .o_if_gnt   (ifGnt[g]),
      .o_if_rvalid(ifRvalid[g]),
      .o_if_rdata (ifRdata[g]),
      .i_d_req    (dReq),
      .i_d_we     (dWe),
      .i_d_addr   (dAddr),
      .i_d_wdata  (dWdata),
      .o_d_gnt    (dGnt[g]),
      .o_d_rvalid (dRvalid[g]),
      .o_d_rdata  (dRdata[g]),
      .o_mem_en   (memEn[g]),
      .o_mem_we   (memWe[g]),
      .o_mem_addr (memAddr[g]),
      .o_mem_wdata(memWdata[g]),
      .i_mem_rdata(memRdata[g]),
      .o_stall    (stall[g])
`ifdef ARB_PERF_CNT_EN
      ,
      .o_if_stall_cnt  (ifStallCnt[g]),
      .o_d_conflict_cnt(dConflictCnt[g])
`endif
    );
  end

  // Memory model: a read is captured at issue and moves one stage per clock,
  // so it appears on memRdata exactly MEM_LAT cycles after issue.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      for (int i = 3; i > 0; i--) pipe[k][i] <= pipe[k][i-1];
      if (memEn[k]) begin
        pipe[k][0] <= memWritten[k][memAddr[k][9:2]] ? memArr[k][memAddr[k][9:2]]
                                                     : (32'hA000_0000 | memAddr[k]);
        if (memWe[k]) begin
          memArr[k][memAddr[k][9:2]]     <= memWdata[k];
          memWritten[k][memAddr[k][9:2]] <= 1'b1;
        end
      end else begin
        pipe[k][0] <= '0;
      end
      if (!rstN) begin
        for (int i = 0; i < 256; i++) memWritten[k][i] <= 1'b0;
      end
    end
  end

  // Return data taps the pipeline stage matching each instance's latency.
  always_comb begin
    for (int k = 0; k < 3; k++) memRdata[k] = pipe[k][k];
  end

  // Stimulus only: clear inputs and pulse reset, then return at a negedge with reset released.
  task automatic applyReset();
    ifReq = 1'b0; ifAddr = '0; dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    ifReq = 1'b1; ifAddr = 32'h10; dReq = 1'b1; dWe = 1'b1; dAddr = 32'h40; dWdata = 32'h1234;
    #2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ifGnt[k], dGnt[k], memEn[k], memWe[k], stall[k], ifRvalid[k], dRvalid[k]} !== 7'b0) begin
        errors++;
        $display("[TB] FAIL reset_ctrl dut%0d got=%b exp=0", k,
                 {ifGnt[k], dGnt[k], memEn[k], memWe[k], stall[k], ifRvalid[k], dRvalid[k]});
      end
      checks++;
      if ((memAddr[k] | memWdata[k] | ifRdata[k] | dRdata[k]) !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_data dut%0d got=%h exp=0", k,
                 memAddr[k] | memWdata[k] | ifRdata[k] | dRdata[k]);
      end
    end
  endtask

  task automatic test_single_fetch();
    applyReset();
    ifReq = 1'b1; ifAddr = 32'h10;
    #2;
    checks++;
    if ({ifGnt[0], memEn[0], memWe[0], stall[0], dGnt[0]} !== 5'b11000) begin
      errors++;
      $display("[TB] FAIL fetch_issue got=%b exp=11000", {ifGnt[0], memEn[0], memWe[0], stall[0], dGnt[0]});
    end
    checks++;
    if (memAddr[0] !== 32'h10) begin
      errors++;
      $display("[TB] FAIL fetch_addr got=%h exp=00000010", memAddr[0]);
    end
    @(negedge clk);
    ifReq = 1'b0; ifAddr = '0;
    #2;
    checks++;
    if (ifRvalid[0] !== 1'b1 || ifRdata[0] !== 32'hA000_0010) begin
      errors++;
      $display("[TB] FAIL fetch_resp got=%b/%h exp=1/a0000010", ifRvalid[0], ifRdata[0]);
    end
    checks++;
    if (memEn[0] !== 1'b0 || dRvalid[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch_quiet got=%b%b exp=00", memEn[0], dRvalid[0]);
    end
    @(negedge clk);
    #2;
    checks++;
    if (ifRvalid[0] !== 1'b0 || ifRdata[0] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL fetch_idle got=%b/%h exp=0/0", ifRvalid[0], ifRdata[0]);
    end
  endtask

  task automatic test_store_load();
    applyReset();
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h40; dWdata = 32'hDEAD_BEEF;
    #2;
    checks++;
    if ({dGnt[1], memEn[1], memWe[1]} !== 3'b111 || memAddr[1] !== 32'h40 || memWdata[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL store_issue got=%b/%h/%h exp=111/00000040/deadbeef",
               {dGnt[1], memEn[1], memWe[1]}, memAddr[1], memWdata[1]);
    end
    @(negedge clk);
    dReq = 1'b0; dWe = 1'b0; dWdata = '0;
    #2;
    checks++;
    if (dRvalid[1] !== 1'b0 || memEn[1] !== 1'b0 || memAddr[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL store_wait got=%b%b/%h exp=00/0", dRvalid[1], memEn[1], memAddr[1]);
    end
    @(negedge clk);
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h40;
    #2;
    checks++;
    if (dRvalid[1] !== 1'b1 || dRdata[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL store_done got=%b/%h exp=1/0", dRvalid[1], dRdata[1]);
    end
    checks++;
    if ({dGnt[1], memEn[1], memWe[1]} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL load_issue got=%b exp=110", {dGnt[1], memEn[1], memWe[1]});
    end
    @(negedge clk);
    dReq = 1'b0;
    #2;
    checks++;
    if (dRvalid[1] !== 1'b0 || dRdata[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL load_wait got=%b/%h exp=0/0", dRvalid[1], dRdata[1]);
    end
    @(negedge clk);
    #2;
    checks++;
    if (dRvalid[1] !== 1'b1 || dRdata[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL load_resp got=%b/%h exp=1/deadbeef", dRvalid[1], dRdata[1]);
    end
  endtask

  task automatic test_contention();
    logic expDGnt  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic expIfGnt [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic expStall [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic expDRv   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic expIfRv  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    applyReset();
    ifReq = 1'b1; ifAddr = 32'h100; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h80;
    for (int c = 0; c < 6; c++) begin
      #2;
      checks++;
      if ({dGnt[0], ifGnt[0], stall[0]} !== {expDGnt[c], expIfGnt[c], expStall[c]}) begin
        errors++;
        $display("[TB] FAIL contend_gnt c%0d got=%b exp=%b", c,
                 {dGnt[0], ifGnt[0], stall[0]}, {expDGnt[c], expIfGnt[c], expStall[c]});
      end
      checks++;
      if ({dRvalid[0], ifRvalid[0]} !== {expDRv[c], expIfRv[c]}) begin
        errors++;
        $display("[TB] FAIL contend_rv c%0d got=%b exp=%b", c,
                 {dRvalid[0], ifRvalid[0]}, {expDRv[c], expIfRv[c]});
      end
      if (expDRv[c]) begin
        checks++;
        if (dRdata[0] !== 32'hA000_0080) begin
          errors++;
          $display("[TB] FAIL contend_drdata c%0d got=%h exp=a0000080", c, dRdata[0]);
        end
      end
      if (expIfRv[c]) begin
        checks++;
        if (ifRdata[0] !== 32'hA000_0100) begin
          errors++;
          $display("[TB] FAIL contend_ifrdata c%0d got=%h exp=a0000100", c, ifRdata[0]);
        end
      end
      @(negedge clk);
    end
    ifReq = 1'b0; dReq = 1'b0;
  endtask

  task automatic test_back_to_back();
    applyReset();
    for (int c = 0; c < 4; c++) begin
      ifReq  = (c < 3);
      ifAddr = 32'(4 * c);
      #2;
      if (c < 3) begin
        checks++;
        if (ifGnt[0] !== 1'b1 || memAddr[0] !== 32'(4 * c)) begin
          errors++;
          $display("[TB] FAIL b2b_gnt c%0d got=%b/%h exp=1/%h", c, ifGnt[0], memAddr[0], 32'(4 * c));
        end
      end
      checks++;
      if (stall[0] !== 1'b0 || ifRvalid[0] !== (c >= 1)) begin
        errors++;
        $display("[TB] FAIL b2b_rv c%0d got=%b%b exp=0%b", c, stall[0], ifRvalid[0], (c >= 1));
      end
      if (c >= 1) begin
        checks++;
        if (ifRdata[0] !== (32'hA000_0000 | 32'(4 * (c - 1)))) begin
          errors++;
          $display("[TB] FAIL b2b_rdata c%0d got=%h exp=%h", c, ifRdata[0], 32'hA000_0000 | 32'(4 * (c - 1)));
        end
      end
      @(negedge clk);
    end
    ifReq = 1'b0;
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    logic [31:0] seenData = '0;
    applyReset();
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h80;
    #2;
    checks++;
    if (dGnt[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_issue got=%b exp=1", dGnt[2]);
    end
    @(negedge clk);
    dReq = 1'b0;
    rstN = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if ({dRvalid[2], dGnt[2], memEn[2], ifRvalid[2]} !== 4'b0 || dRdata[2] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL midrst_hold c%0d got=%b/%h exp=0/0", c,
                 {dRvalid[2], dGnt[2], memEn[2], ifRvalid[2]}, dRdata[2]);
      end
      @(negedge clk);
    end
    rstN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if (dRvalid[2] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_dropped c%0d got=%b exp=0", c, dRvalid[2]);
      end
      @(negedge clk);
    end
    ifReq = 1'b1; ifAddr = 32'h20;
    #2;
    checks++;
    if (ifGnt[2] !== 1'b1 || memAddr[2] !== 32'h20) begin
      errors++;
      $display("[TB] FAIL midrst_fetch_gnt got=%b/%h exp=1/00000020", ifGnt[2], memAddr[2]);
    end
    @(negedge clk);
    ifReq = 1'b0; ifAddr = '0;
    for (int c = 1; c <= 8; c++) begin
      #2;
      if (ifRvalid[2] === 1'b1) begin
        seen = c;
        seenData = ifRdata[2];
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (seen != 3 || seenData !== 32'hA000_0020) begin
      errors++;
      $display("[TB] FAIL midrst_fetch_resp got=cycle%0d/%h exp=cycle3/a0000020", seen, seenData);
    end
    @(negedge clk);
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf_counters();
    applyReset();
    #2;
    checks++;
    if (ifStallCnt[0] !== 32'd0 || dConflictCnt[0] !== 32'd0) begin
      errors++;
      $display("[TB] FAIL perf_reset got=%0d/%0d exp=0/0", ifStallCnt[0], dConflictCnt[0]);
    end
    ifReq = 1'b1; ifAddr = 32'h100; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h80;
    repeat (8) @(negedge clk);
    ifReq = 1'b0; dReq = 1'b0;
    #2;
    checks++;
    if (ifStallCnt[0] !== 32'd6 || dConflictCnt[0] !== 32'd8) begin
      errors++;
      $display("[TB] FAIL perf_counts got=%0d/%0d exp=6/8", ifStallCnt[0], dConflictCnt[0]);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_back_to_back();
    test_mid_reset();
`ifdef ARB_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
